// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit holding the HI/LO register pair.
// One bit per cycle in CALC, sign fix-up and HI/LO write in FIX, done pulse in DONE.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_MD_start,
  input  logic [OPW-1:0]   i_MD_op,
  input  logic [WIDTH-1:0] i_MD_srcA,
  input  logic [WIDTH-1:0] i_MD_srcB,
  input  logic             i_MD_cancel,
  output logic [WIDTH-1:0] o_MD_hi,
  output logic [WIDTH-1:0] o_MD_lo,
  output logic             o_MD_busy,
  output logic             o_MD_done,
  output logic             o_MD_dz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [OPW-1:0] OP_MULT  = OPW'(14);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(16);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(17);
  localparam logic [OPW-1:0] OP_MTHI  = OPW'(18);
  localparam logic [OPW-1:0] OP_MTLO  = OPW'(19);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_acc, r_q, r_opb, r_srca;
  logic             r_neg_a, r_neg_b, r_signed, r_div, r_bzero, r_dz;

  logic             w_is_md, w_in_signed, w_in_div;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_add, w_shift;
  logic [WIDTH-1:0] w_sub, w_acc_next, w_q_next;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

  assign w_is_md     = (i_MD_op == OP_MULT) || (i_MD_op == OP_MULTU) ||
                       (i_MD_op == OP_DIV)  || (i_MD_op == OP_DIVU);
  assign w_in_signed = (i_MD_op == OP_MULT) || (i_MD_op == OP_DIV);
  assign w_in_div    = (i_MD_op == OP_DIV)  || (i_MD_op == OP_DIVU);
  assign w_mag_a = (w_in_signed && i_MD_srcA[WIDTH-1]) ? -i_MD_srcA : i_MD_srcA;
  assign w_mag_b = (w_in_signed && i_MD_srcB[WIDTH-1]) ? -i_MD_srcB : i_MD_srcB;

  // r_opb holds the multiplicand or divisor magnitude; r_q the multiplier or dividend.
  // The low WIDTH bits of the trial difference are exact whenever it is kept.
  always_comb begin
    w_add   = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_opb : '0)};
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_opb});
    w_sub   = w_shift[WIDTH-1:0] - r_opb;
    if (r_div) begin
      w_acc_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
      w_q_next   = {r_q[WIDTH-2:0], w_ge};
    end else begin
      w_acc_next = w_add[WIDTH:1];
      w_q_next   = {w_add[0], r_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod   = (r_signed && (r_neg_a ^ r_neg_b)) ? -{r_acc, r_q} : {r_acc, r_q};
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_bzero) begin
        w_fix_hi = r_srca;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = (r_signed && r_neg_a) ? -r_acc : r_acc;
        w_fix_lo = (r_signed && (r_neg_a ^ r_neg_b)) ? -r_q : r_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (i_MD_start && w_is_md) w_state_next = CALC;
      CALC: begin
        if (i_MD_cancel)                     w_state_next = IDLE;
        else if (r_cnt == CW'(WIDTH - 1))    w_state_next = FIX;
      end
      FIX:  w_state_next = i_MD_cancel ? IDLE : DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opb    <= '0;
      r_srca   <= '0;
      r_cnt    <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_signed <= 1'b0;
      r_div    <= 1'b0;
      r_bzero  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_MD_start) begin
          if (w_is_md) begin
            r_acc    <= '0;
            r_q      <= w_in_div ? w_mag_a : w_mag_b;
            r_opb    <= w_in_div ? w_mag_b : w_mag_a;
            r_srca   <= i_MD_srcA;
            r_neg_a  <= i_MD_srcA[WIDTH-1];
            r_neg_b  <= i_MD_srcB[WIDTH-1];
            r_signed <= w_in_signed;
            r_div    <= w_in_div;
            r_bzero  <= (i_MD_srcB == '0);
            r_cnt    <= '0;
            r_dz     <= 1'b0;
          end else if (i_MD_op == OP_MTHI) begin
            r_hi <= i_MD_srcA;
          end else if (i_MD_op == OP_MTLO) begin
            r_lo <= i_MD_srcA;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: if (!i_MD_cancel) begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
          if (r_div) r_dz <= r_bzero;
        end
        default: ;
      endcase
    end
  end

  assign o_MD_hi   = r_hi;
  assign o_MD_lo   = r_lo;
  assign o_MD_busy = (r_state == CALC) || (r_state == FIX);
  assign o_MD_done = (r_state == DONE);
  assign o_MD_dz   = r_dz;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32: arithmetic results, latency,
// HI/LO moves, cancel and reset behaviour.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] srca = '0, srcb = '0;
  logic [31:0] hi, lo;
  logic        busy, done, dz;

  int total = 0;
  int bad = 0;
  int lat, bcnt, dcnt;

  alu_muldiv #(.WIDTH(32), .OPW(5)) dut (
    .clk(clk), .rst(rst), .i_MD_start(start), .i_MD_op(op),
    .i_MD_srcA(srca), .i_MD_srcB(srcb), .i_MD_cancel(cancel),
    .o_MD_hi(hi), .o_MD_lo(lo), .o_MD_busy(busy), .o_MD_done(done), .o_MD_dz(dz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Cycles counted from the start edge until done is seen (bounded).
  task automatic wait_done(input int from, output int cyc, output int busy_cycles);
    cyc = from;
    busy_cycles = 0;
    while (!done && cyc < 60) begin
      if (busy) busy_cycles++;
      tick();
      cyc++;
    end
  endtask

  task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int l, output int bc);
    start = 1'b1; op = o; srca = x; srcb = y;
    tick();
    start = 1'b0;
    wait_done(1, l, bc);
  endtask

  task automatic watch_idle(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      tick();
      if (done) dones++;
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    rst = 1'b0;
    tick();

    do_op(14, 32'hFFFFFFFD, 32'd5, lat, bcnt);
    chk("mult_lat", lat, 34);
    chk("mult_busy_cycles", bcnt, 33);
    chk("mult_done", done, 1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    tick();
    chk("mult_done_pulse", done, 0);

    do_op(15, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    tick();

    do_op(14, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    chk("mult_m1_hi", hi, 0);
    chk("mult_m1_lo", lo, 1);
    tick();

    do_op(16, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    chk("div_n7_2_lo", lo, 32'hFFFFFFFD);
    chk("div_n7_2_hi", hi, 32'hFFFFFFFF);
    chk("div_n7_2_dz", dz, 0);
    tick();

    do_op(16, 32'd7, 32'hFFFFFFFE, lat, bcnt);
    chk("div_7_n2_lo", lo, 32'hFFFFFFFD);
    chk("div_7_n2_hi", hi, 1);
    tick();

    do_op(16, 32'hFFFFFFF9, 32'hFFFFFFFE, lat, bcnt);
    chk("div_n7_n2_lo", lo, 3);
    chk("div_n7_n2_hi", hi, 32'hFFFFFFFF);
    tick();

    do_op(16, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    chk("div_min_lo", lo, 32'h80000000);
    chk("div_min_hi", hi, 0);
    chk("div_min_dz", dz, 0);
    tick();

    do_op(17, 32'd100, 32'd7, lat, bcnt);
    chk("divu_100_7_lo", lo, 14);
    chk("divu_100_7_hi", hi, 2);
    tick();

    do_op(17, 32'd7, 32'd0, lat, bcnt);
    chk("divu_z_lat", lat, 34);
    chk("divu_z_lo", lo, 32'hFFFFFFFF);
    chk("divu_z_hi", hi, 7);
    chk("divu_z_dz", dz, 1);
    tick();
    chk("dz_held_idle", dz, 1);

    start = 1'b1; op = 15; srca = 32'd3; srcb = 32'd4;
    tick();
    start = 1'b0;
    chk("dz_clr_on_start", dz, 0);
    chk("busy_after_start", busy, 1);
    chk("hilo_held_busy", hi, 7);
    wait_done(1, lat, bcnt);
    chk("multu_3_4_lo", lo, 12);
    chk("multu_3_4_hi", hi, 0);
    tick();

    start = 1'b1; op = 18; srca = 32'h1234;
    tick();
    chk("mthi_busy", busy, 0);
    chk("mthi_hi", hi, 32'h1234);
    op = 19; srca = 32'h5678;
    tick();
    start = 1'b0;
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);
    chk("mtlo_hi", hi, 32'h1234);
    chk("mtlo_lo", lo, 32'h5678);

    start = 1'b1; op = 15; srca = 32'd2; srcb = 32'd3;
    tick();
    op = 19; srca = 32'hDEAD;
    tick();
    start = 1'b0;
    chk("mtlo_busy_lo", lo, 32'h5678);
    chk("mtlo_busy_busy", busy, 1);
    wait_done(2, lat, bcnt);
    chk("mtlo_busy_lat", lat, 34);
    chk("multu_2_3_lo", lo, 6);
    chk("multu_2_3_hi", hi, 0);
    tick();

    start = 1'b1; op = 15; srca = 32'd5; srcb = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    chk("cancel10_busy_before", busy, 1);
    tick();
    cancel = 1'b0;
    chk("cancel10_busy_after", busy, 0);
    watch_idle(40, dcnt);
    chk("cancel10_no_done", dcnt, 0);
    chk("cancel10_hi", hi, 0);
    chk("cancel10_lo", lo, 6);

    start = 1'b1; op = 15; srca = 32'd5; srcb = 32'd7;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("cancelfix_busy_before", busy, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancelfix_busy_after", busy, 0);
    chk("cancelfix_lo", lo, 6);
    watch_idle(40, dcnt);
    chk("cancelfix_no_done", dcnt, 0);
    chk("cancelfix_lo_later", lo, 6);

    start = 1'b1; op = 16; srca = 32'd100; srcb = 32'd3;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dz", dz, 0);
    watch_idle(40, dcnt);
    chk("midrst_no_done", dcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
